mux_edge_counter: RTL and testbench
===================================

// Module: mux_edge_counter
// PURPOSE
//  Downstream monitor for the 2:1 select-mux output Y0. Synchronises and
//  debounces the mux output, counts its debounced rising edges, and returns
//  the count through a four-phase snapshot handshake. Sits directly after the
//  mux inside the tile top; its results drive the otherwise unused output pins.
// PARAMETERS
//  SYNC_STAGES      2  flops in the input synchroniser chain (>=2)
//  DEBOUNCE_CYCLES  4  consecutive differing samples needed to commit a new level (>=1)
//  CNT_W            8  edge counter and snapshot width
// PORTS
//  clk       in   1      single clock, rising edge
//  rst_n     in   1      reset, asynchronous assert, active low
//  ena       in   1      count enable; debounce keeps running when low
//  sel_in    in   1      mux output Y0; asynchronous to clk
//  clr       in   1      synchronous clear of live count and ovf
//  snap_req  in   1      snapshot request, level, synchronous to clk
//  snap_ack  out  1      snapshot acknowledge, level
//  cnt_q     out  CNT_W  captured count; holds until the next snapshot
//  level     out  1      debounced level of sel_in
//  ovf       out  1      sticky wrap flag of the live count
// BEHAVIOUR
//  Reset: cnt_q=0, snap_ack=0, level=0, ovf=0, live count=0, sync chain=0,
//   stab_cnt=0, FSM=IDLE. Takes effect immediately on any cycle, mid-handshake included.
//  Sync: sel_in passes through SYNC_STAGES flops; the last stage is sync_q.
//  Debounce: stab_cnt clears whenever sync_q==level. On each edge with
//   sync_q!=level, stab_cnt increments. The edge on which stab_cnt==DEBOUNCE_CYCLES-1
//   is the commit edge: level<=sync_q and stab_cnt<=0.
//   A step on sel_in held stable appears on level after exactly
//   SYNC_STAGES+DEBOUNCE_CYCLES edges (6 at defaults). Shorter pulses are
//   discarded.
//  Count: on a commit edge where level goes 0->1 and ena=1, the live count
//   increments on the same edge. From all-ones the count wraps to 0 and ovf<=1.
//   ovf is sticky until clr or reset.
//  clr: on that edge, the live count<=0 and ovf<=0. clr wins over a
//   simultaneous increment. clr does not change cnt_q, snap_ack or the FSM.
//  Level after reset: level restarts at 0, so sel_in=1 at reset release counts
//   as one edge after the full latency.
//  Snapshot FSM: two states, IDLE and ACK.
//   IDLE: snap_req=1 -> cnt_q<=live count (value before this edge's
//    increment/clr), snap_ack<=1, next state ACK.
//   ACK: cnt_q is frozen. snap_req=0 -> snap_ack<=0, next state IDLE.
//   snap_ack therefore rises 1 edge after snap_req rises and falls 1 edge
//   after snap_req falls. Counting continues in both states.
//   A snap_req that stays high after ack does not start a second capture.
//  All outputs come straight from registers; no combinational input-to-output path.
// STRUCTURE
//  mux_mon_pkg: snap_state_e {IDLE, ACK} and default parameter constants.
//  Sub-module in_sync_debounce (params SYNC_STAGES, DEBOUNCE_CYCLES):
//   sel_in -> level, rise_pulse (single cycle, asserted on the 0->1 commit edge).
//  Top level: counter, ovf, snapshot FSM, cnt_q register.
// TESTING
//  1 rst_n=0 with sel_in=1 -> all outputs 0. Release, hold sel_in=1 ->
//    level=1 on the 6th edge. Snapshot -> cnt_q=1.
//  2 sel_in high for 3 cycles then low -> level stays 0. Snapshot -> cnt_q=0.
//  3 10 pulses of 8 cycles high / 8 low, ena=1 -> snapshot cnt_q=10, ovf=0.
//  4 257 clean pulses -> snapshot cnt_q=1, ovf=1. clr then snapshot ->
//    cnt_q=0, ovf=0.
//  5 ena=0 for 5 pulses after count=3 -> level toggles 5 times; snapshot cnt_q=3.
//  6 snap_req held 5 cycles while pulses arrive -> ack high 1 edge after req,
//    cnt_q frozen, ack low 1 edge after req drops. clr on a commit edge ->
//    next snapshot=0. rst_n pulsed while in ACK -> snap_ack=0 and FSM=IDLE.

Source files
------------

// File: rtl/mux_mon_pkg.sv
// Shared types and default parameters for the mux output monitor.
package mux_mon_pkg;
    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int CNT_W_DEF           = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACK  = 1'b1
    } snap_state_e;
endpackage

// File: rtl/in_sync_debounce.sv
// Synchroniser and debouncer for the asynchronous mux output.
// rise_pulse is high in the cycle whose closing edge commits a 0->1 level.
module in_sync_debounce
    import mux_mon_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sel_in,
    output logic level,
    output logic rise_pulse
);
    localparam int SW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [SW-1:0] LAST = SW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SW-1:0]          r_stab;
    logic                   r_level;
    logic                   w_sync_q;
    logic                   w_commit;

    assign w_sync_q   = r_sync[SYNC_STAGES-1];
    assign w_commit   = (w_sync_q != r_level) && (r_stab == LAST);
    assign rise_pulse = w_commit && w_sync_q;
    assign level      = r_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= '0;
            r_stab  <= '0;
            r_level <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sel_in};
            if (w_sync_q == r_level) begin
                r_stab <= '0;
            end else if (w_commit) begin
                r_level <= w_sync_q;
                r_stab  <= '0;
            end else begin
                r_stab <= r_stab + 1'b1;
            end
        end
    end
endmodule

// File: rtl/mux_edge_counter.sv
// Counts debounced rising edges of the mux output and returns the
// count through a level-based four-phase snapshot handshake.
module mux_edge_counter
    import mux_mon_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             sel_in,
    input  logic             clr,
    input  logic             snap_req,
    output logic             snap_ack,
    output logic [CNT_W-1:0] cnt_q,
    output logic             level,
    output logic             ovf
);
    logic             w_rise;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic [CNT_W-1:0] r_cnt_q;
    logic             r_ack;
    snap_state_e      r_state;

    in_sync_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
        .clk       (clk),
        .rst_n     (rst_n),
        .sel_in    (sel_in),
        .level     (level),
        .rise_pulse(w_rise)
    );

    // clr takes priority over a coincident increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (clr) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_rise && ena) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == '1) begin
                r_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
            r_cnt_q <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (snap_req) begin
                        r_cnt_q <= r_cnt;
                        r_ack   <= 1'b1;
                        r_state <= ACK;
                    end
                end
                ACK: begin
                    if (!snap_req) begin
                        r_ack   <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ack   <= 1'b0;
                end
            endcase
        end
    end

    assign snap_ack = r_ack;
    assign cnt_q    = r_cnt_q;
    assign ovf      = r_ovf;
endmodule

// File: tb/tb_mux_edge_counter.sv
// Directed self-checking bench for mux_edge_counter.
module tb_mux_edge_counter;
    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       sel_in;
    logic       clr;
    logic       snap_req;
    logic       snap_ack;
    logic [7:0] cnt_q;
    logic       level;
    logic       ovf;

    int n_cmp;
    int n_err;
    int rises;
    logic prev_lvl;

    mux_edge_counter dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .sel_in  (sel_in),
        .clr     (clr),
        .snap_req(snap_req),
        .snap_ack(snap_ack),
        .cnt_q   (cnt_q),
        .level   (level),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int hi, input int lo);
        sel_in = 1'b1;
        repeat (hi) begin
            @(negedge clk);
            if (level && !prev_lvl) rises++;
            prev_lvl = level;
        end
        sel_in = 1'b0;
        repeat (lo) begin
            @(negedge clk);
            prev_lvl = level;
        end
    endtask

    task automatic do_snap();
        snap_req = 1'b1;
        step(1);
        snap_req = 1'b0;
        step(1);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step(1);
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sel_in = 1'b1; ena = 1'b1;
        clr = 1'b0; snap_req = 1'b0;
        step(2);
        n_cmp++;
        if ({cnt_q, snap_ack, level, ovf} !== 11'd0) begin
            n_err++;
            $display("FAIL reset_outputs got cnt_q=%0d ack=%b lvl=%b ovf=%b want all 0",
                     cnt_q, snap_ack, level, ovf);
        end
        rst_n = 1'b1;
        step(5);
        n_cmp++;
        if (level !== 1'b0) begin
            n_err++;
            $display("FAIL latency_edge5 got level=%b want 0", level);
        end
        step(1);
        n_cmp++;
        if (level !== 1'b1) begin
            n_err++;
            $display("FAIL latency_edge6 got level=%b want 1", level);
        end
        snap_req = 1'b1;
        step(1);
        n_cmp++;
        if (snap_ack !== 1'b1 || cnt_q !== 8'd1) begin
            n_err++;
            $display("FAIL reset_snap got ack=%b cnt_q=%0d want ack=1 cnt_q=1",
                     snap_ack, cnt_q);
        end
        snap_req = 1'b0;
        step(1);
        n_cmp++;
        if (snap_ack !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ack_fall got %b want 0", snap_ack);
        end
        sel_in = 1'b0;
        step(8);
    endtask

    task automatic test_glitch();
        logic seen;
        do_clr();
        seen = 1'b0;
        sel_in = 1'b1;
        repeat (3) begin
            step(1);
            seen |= level;
        end
        sel_in = 1'b0;
        repeat (10) begin
            step(1);
            seen |= level;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL glitch_level got high=%b want 0", seen);
        end
        do_snap();
        n_cmp++;
        if (cnt_q !== 8'd0) begin
            n_err++;
            $display("FAIL glitch_snap got cnt_q=%0d want 0", cnt_q);
        end
    endtask

    task automatic test_count();
        do_clr();
        for (int i = 0; i < 10; i++) pulse(8, 8);
        do_snap();
        n_cmp++;
        if (cnt_q !== 8'd10 || ovf !== 1'b0) begin
            n_err++;
            $display("FAIL count10 got cnt_q=%0d ovf=%b want 10 ovf=0", cnt_q, ovf);
        end
    endtask

    task automatic test_wrap();
        do_clr();
        for (int i = 0; i < 257; i++) pulse(8, 8);
        do_snap();
        n_cmp++;
        if (cnt_q !== 8'd1 || ovf !== 1'b1) begin
            n_err++;
            $display("FAIL wrap257 got cnt_q=%0d ovf=%b want 1 ovf=1", cnt_q, ovf);
        end
        do_clr();
        do_snap();
        n_cmp++;
        if (cnt_q !== 8'd0 || ovf !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_clr got cnt_q=%0d ovf=%b want 0 ovf=0", cnt_q, ovf);
        end
    endtask

    task automatic test_enable();
        do_clr();
        for (int i = 0; i < 3; i++) pulse(8, 8);
        ena = 1'b0;
        rises = 0;
        prev_lvl = level;
        for (int i = 0; i < 5; i++) pulse(8, 8);
        ena = 1'b1;
        n_cmp++;
        if (rises !== 5) begin
            n_err++;
            $display("FAIL ena_toggles got rises=%0d want 5", rises);
        end
        do_snap();
        n_cmp++;
        if (cnt_q !== 8'd3) begin
            n_err++;
            $display("FAIL ena_snap got cnt_q=%0d want 3", cnt_q);
        end
    endtask

    task automatic test_handshake();
        do_clr();
        sel_in = 1'b1;
        step(3);
        snap_req = 1'b1;
        step(1);
        n_cmp++;
        if (snap_ack !== 1'b1 || cnt_q !== 8'd0) begin
            n_err++;
            $display("FAIL hs_rise got ack=%b cnt_q=%0d want ack=1 cnt_q=0",
                     snap_ack, cnt_q);
        end
        step(4);
        n_cmp++;
        if (snap_ack !== 1'b1 || cnt_q !== 8'd0 || level !== 1'b1) begin
            n_err++;
            $display("FAIL hs_frozen got ack=%b cnt_q=%0d lvl=%b want 1,0,1",
                     snap_ack, cnt_q, level);
        end
        snap_req = 1'b0;
        step(1);
        n_cmp++;
        if (snap_ack !== 1'b0) begin
            n_err++;
            $display("FAIL hs_fall got ack=%b want 0", snap_ack);
        end
        sel_in = 1'b0;
        step(8);
        do_snap();
        n_cmp++;
        if (cnt_q !== 8'd1) begin
            n_err++;
            $display("FAIL hs_counted got cnt_q=%0d want 1", cnt_q);
        end
        sel_in = 1'b1;
        step(5);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        n_cmp++;
        if (level !== 1'b1) begin
            n_err++;
            $display("FAIL clr_commit_lvl got level=%b want 1", level);
        end
        sel_in = 1'b0;
        step(8);
        do_snap();
        n_cmp++;
        if (cnt_q !== 8'd0) begin
            n_err++;
            $display("FAIL clr_commit got cnt_q=%0d want 0", cnt_q);
        end
    endtask

    task automatic test_reset_in_ack();
        pulse(8, 8);
        snap_req = 1'b1;
        step(1);
        n_cmp++;
        if (snap_ack !== 1'b1 || cnt_q !== 8'd1) begin
            n_err++;
            $display("FAIL rack_pre got ack=%b cnt_q=%0d want 1,1", snap_ack, cnt_q);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (snap_ack !== 1'b0 || cnt_q !== 8'd0) begin
            n_err++;
            $display("FAIL rack_async got ack=%b cnt_q=%0d want 0,0", snap_ack, cnt_q);
        end
        step(1);
        rst_n = 1'b1;
        step(1);
        n_cmp++;
        if (snap_ack !== 1'b1 || cnt_q !== 8'd0 || ovf !== 1'b0) begin
            n_err++;
            $display("FAIL rack_idle got ack=%b cnt_q=%0d ovf=%b want 1,0,0",
                     snap_ack, cnt_q, ovf);
        end
        snap_req = 1'b0;
        step(2);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rises = 0;
        prev_lvl = 1'b0;
        test_reset();
        test_glitch();
        test_count();
        test_wrap();
        test_enable();
        test_handshake();
        test_reset_in_ack();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
